// File: rtl/counter_job_scheduler.sv
// counter_job_scheduler: round-robin job scheduler sharing one up/down counter among NREQ requesters
module counter_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = (1 << WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid_i,
  output logic [NREQ-1:0]          req_ready_o,
  input  logic [NREQ*WIDTH-1:0]    req_value_i,
  input  logic [NREQ-1:0]          req_up_i,
  input  logic                     abort_i,
  output logic                     ctr_en_o,
  output logic                     ctr_up_down_o,
  output logic                     ctr_load_o,
  output logic [WIDTH-1:0]         ctr_load_value_o,
  input  logic                     ctr_tc_i,
  output logic [NREQ-1:0]          done_o,
  output logic [1:0]               done_status_o,
  output logic                     busy_o,
  output logic [$clog2(NREQ)-1:0]  owner_o
);
  localparam int IW = $clog2(NREQ);
  localparam int RW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, GRANT, LOAD, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick;
  logic [WIDTH-1:0] val_q, val_d;
  logic up_q, up_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [1:0] status_q, status_d;
  logic [NREQ-1:0] ready_q, ready_d;
  assign req_ready_o      = ready_q;
  assign ctr_up_down_o    = up_q;
  assign ctr_load_value_o = val_q;
  assign busy_o           = state_q != IDLE;
  assign owner_o          = owner_q;
  assign done_o           = (state_q == DONE) ? NREQ'(1) << owner_q : '0;
  assign done_status_o    = (state_q == DONE) ? status_q : 2'b00;
  // round-robin pick: nearest valid requester after the last grant (descending scan so the nearest wins)
  always_comb begin
    pick = last_q;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid_i[(int'(last_q) + k) % NREQ]) pick = IW'((int'(last_q) + k) % NREQ);
  end
  // next-state logic and counter control
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    val_d      = val_q;
    up_d       = up_q;
    rc_d       = rc_q;
    status_d   = status_q;
    ready_d    = '0;
    ctr_en_o   = 1'b0;
    ctr_load_o = 1'b0;
    case (state_q)
      IDLE: if (|req_valid_i) begin
        owner_d = pick;
        ready_d = NREQ'(1) << pick;
        state_d = GRANT;
      end
      GRANT: if (req_valid_i[owner_q]) begin
        val_d   = req_value_i[owner_q*WIDTH +: WIDTH];
        up_d    = req_up_i[owner_q];
        state_d = LOAD;
      end else state_d = IDLE;
      LOAD: begin
        ctr_load_o = 1'b1;
        rc_d       = '0;
        status_d   = abort_i ? 2'b01 : 2'b00;
        state_d    = abort_i ? DONE : RUN;
      end
      RUN: begin
        ctr_en_o = !ctr_tc_i && !abort_i && (rc_q != RW'(TIMEOUT - 1));
        rc_d     = rc_q + 1'b1;
        if (abort_i) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else if (ctr_tc_i) begin
          status_d = 2'b00;
          state_d  = DONE;
        end else if (rc_q == RW'(TIMEOUT - 1)) begin
          status_d = 2'b10;
          state_d  = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and job registers; reset leaves requester 0 first in line
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NREQ - 1);
      val_q    <= '0;
      up_q     <= 1'b1;
      rc_q     <= '0;
      status_q <= 2'b00;
      ready_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      val_q    <= val_d;
      up_q     <= up_d;
      rc_q     <= rc_d;
      status_q <= status_d;
      ready_q  <= ready_d;
    end
endmodule

// File: tb/tb_counter_job_scheduler.sv
// tb_counter_job_scheduler: directed plus random jobs against a latency/round-robin reference model
module tb_counter_job_scheduler;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] req_valid = 0, req_ready, req_up = 0, done;
  logic [31:0] req_value = 0;
  logic abort = 0, ctr_en, ctr_up_down, ctr_load, ctr_tc, busy;
  logic [7:0] ctr_load_value;
  logic [1:0] done_status, owner;
  logic [7:0] cnt = 0;
  logic stuck = 0;
  int tests = 0, fails = 0, cyc = 0, last_m = 3;
  logic [3:0] rd, d;
  logic [1:0] s;
  int ens, r;

  counter_job_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_value_i(req_value), .req_up_i(req_up), .abort_i(abort), .ctr_en_o(ctr_en),
    .ctr_up_down_o(ctr_up_down), .ctr_load_o(ctr_load), .ctr_load_value_o(ctr_load_value),
    .ctr_tc_i(ctr_tc), .done_o(done), .done_status_o(done_status), .busy_o(busy), .owner_o(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // shared counter: load beats enable; tc can be forced low to provoke a timeout
  always @(posedge clk)
    if (ctr_load) cnt <= ctr_load_value;
    else if (ctr_en) cnt <= ctr_up_down ? cnt + 8'd1 : cnt - 8'd1;
  assign ctr_tc = !stuck && (ctr_up_down ? cnt == 8'hFF : cnt == 8'h00);

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic wait_ready(output logic [3:0] rdy);
    rdy = 0;
    for (int i = 0; i < 20 && rdy == 0; i++) begin
      @(negedge clk);
      rdy = req_ready;
    end
    chk("ready_seen", rdy != 0, 1);
  endtask

  task automatic wait_done(output logic [3:0] dv, output logic [1:0] st, output int en_n);
    en_n = 0; dv = 0; st = 0;
    for (int i = 0; i < 400 && dv == 0; i++) begin
      @(negedge clk);
      if (done != 0) begin
        dv = done;
        st = done_status;
      end else if (ctr_en) en_n++;
    end
    chk("done_seen", dv != 0, 1);
  endtask

  // one job from a lone requester; expectations come from the start value and direction alone
  task automatic job(input int rq, input logic [7:0] v, input logic up);
    int t0, steps;
    logic [3:0] dv;
    logic [1:0] st;
    int en_n;
    steps = up ? 255 - v : v;
    req_value[rq*8 +: 8] = v;
    req_up[rq] = up;
    req_valid[rq] = 1;
    t0 = cyc;
    @(negedge clk);
    chk("ready", req_ready, 4'b1 << rq);
    chk("owner", owner, rq);
    @(negedge clk);
    req_valid[rq] = 0;
    chk("load", {ctr_load, ctr_en, ctr_up_down, ctr_load_value}, {1'b1, 1'b0, up, v});
    wait_done(dv, st, en_n);
    chk("latency", cyc - t0, stuck ? 260 : 4 + steps);
    chk("done_vec", dv, 4'b1 << rq);
    chk("status", st, stuck ? 2 : 0);
    chk("steps", en_n, stuck ? 256 : steps);
    if (!stuck) chk("final_cnt", cnt, up ? 255 : 0);
    chk("busy_done", busy, 1);
    @(negedge clk);
    chk("busy_idle", busy, 0);
    last_m = rq;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {req_ready, done, done_status, ctr_en, ctr_load, busy, owner, ctr_load_value, ctr_up_down}, 24'h000001);
    rst_n = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    job(0, 8'd250, 1'b1);
    job(2, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) job($urandom_range(3, 0), 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
    // round robin with everyone requesting
    req_up = '1;
    req_value = {4{8'd254}};
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      r = rr_pick(req_valid, last_m);
      wait_ready(rd);
      chk("rr_grant", rd, 4'b1 << r);
      wait_done(d, s, ens);
      chk("rr_done", d, 4'b1 << r);
      chk("rr_steps", ens, 1);
      if (k == 4) req_valid = 0;
      last_m = r;
    end
    @(negedge clk);
    // abort on the third RUN cycle of a down job
    r = (last_m + 1) % 4;
    req_value[r*8 +: 8] = 8'd100;
    req_up[r] = 0;
    req_valid[r] = 1;
    @(negedge clk);
    chk("ab_ready", req_ready, 4'b1 << r);
    @(negedge clk);
    req_valid[r] = 0;
    @(negedge clk);
    chk("ab_run1_en", ctr_en, 1);
    @(negedge clk);
    chk("ab_run2_en", ctr_en, 1);
    @(negedge clk);
    abort = 1;
    #1;
    chk("ab_en_low", ctr_en, 0);
    @(negedge clk);
    abort = 0;
    chk("ab_done", {done, done_status}, {4'b1 << r, 2'b01});
    chk("ab_cnt", cnt, 8'd98);
    last_m = r;
    req_value = {4{8'd255}};
    req_up = '1;
    req_valid = '1;
    r = rr_pick(req_valid, last_m);
    wait_ready(rd);
    chk("ab_next_grant", rd, 4'b1 << r);
    wait_done(d, s, ens);
    req_valid = 0;
    chk("ab_next_done", {d, s}, {4'b1 << r, 2'b00});
    last_m = r;
    @(negedge clk);
    // watchdog: tc never arrives
    stuck = 1;
    job((last_m + 1) % 4, 8'd10, 1'b1);
    stuck = 0;
    // reset in the middle of RUN
    r = (last_m + 1) % 4;
    req_value[r*8 +: 8] = 8'd50;
    req_up[r] = 0;
    req_valid[r] = 1;
    @(negedge clk);
    @(negedge clk);
    req_valid[r] = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rs_running", ctr_en, 1);
    rst_n = 0;
    #1;
    chk("rs_outs", {req_ready, done, done_status, ctr_en, ctr_load, busy, owner, ctr_load_value, ctr_up_down}, 24'h000001);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rs_no_done", done, 0);
    end
    rst_n = 1;
    last_m = 3;
    req_value = {4{8'd255}};
    req_up = '1;
    req_valid = '1;
    wait_ready(rd);
    chk("rs_grant0", rd, 4'b1 << rr_pick(4'b1111, last_m));
    wait_done(d, s, ens);
    req_valid = 0;
    chk("rs_done0", {d, s}, 6'b0001_00);
    last_m = 0;
    @(negedge clk);
    // requester drops valid while granted
    req_valid = 4'b0010;
    @(negedge clk);
    chk("vd_ready", req_ready, 4'b0010);
    req_valid = 0;
    @(negedge clk);
    chk("vd_no_load", {ctr_load, busy}, 2'b00);
    @(negedge clk);
    req_valid = 4'b0011;
    wait_ready(rd);
    chk("vd_rr_kept", rd, 4'b1 << rr_pick(4'b0011, last_m));
    wait_done(d, s, ens);
    req_valid = 0;
    chk("vd_done", {d, s}, 6'b0010_00);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_job_scheduler.md
Name: counter_job_scheduler

Overview:
- Shares one loadable up/down counter datapath (en, up_down, load, load_value in; tc out) among NREQ requesters.
- Each requester submits a job (start value plus direction). The scheduler arbitrates round-robin, loads the counter, enables it until terminal count, then returns a per-requester done pulse with status.
- Sits between the software/timer clients and the shared counter instance. Includes abort and watchdog timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, counter width; MAX = 2^WIDTH-1.
- TIMEOUT, 2^WIDTH+1, RUN cycles without ctr_tc before the job is killed.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  job request per requester; must hold high until its req_ready.
- req_ready  out  NREQ  one-hot handshake accept, registered.
- req_value  in  NREQ*WIDTH  start value; requester i uses bits [i*WIDTH +: WIDTH].
- req_up  in  NREQ  direction per requester; 1 = count up to MAX, 0 = count down to 0.
- abort  in  1  terminates the active job.
- ctr_en  out  1  counter enable.
- ctr_up_down  out  1  counter direction.
- ctr_load  out  1  counter synchronous load.
- ctr_load_value  out  WIDTH  counter load data.
- ctr_tc  in  1  counter terminal count; combinational from the counter (up & count==MAX, or down & count==0).
- done  out  NREQ  one-hot, one-cycle job-complete pulse.
- done_status  out  2  valid with done: 00 = tc reached, 01 = aborted, 10 = timeout.
- busy  out  1  high in every state except IDLE.
- owner  out  $clog2(NREQ)  index of the current or last granted requester.

Behaviour:
- Counter contract: load has priority over en. Counter updates on the next edge; en=0 with load=0 holds the count.
- Reset (async, rst_n low): state=IDLE; req_ready, done, done_status, ctr_en, ctr_load, ctr_load_value, busy, owner all 0. ctr_up_down=1. RR pointer set so requester 0 has highest priority on the first arbitration. An active job is dropped silently, with no done pulse.
- FSM states: IDLE, GRANT, LOAD, RUN, DONE.
- IDLE:
  - If any req_valid, pick the first valid requester at or after (last_grant+1) mod NREQ.
  - Register it in owner; next state GRANT. Otherwise stay in IDLE.
- GRANT:
  - req_ready[owner]=1 for exactly one cycle.
  - If req_valid[owner]=1: capture req_value and req_up into job registers; next state LOAD.
  - If req_valid[owner]=0 (protocol violation): no capture, return to IDLE, RR pointer unchanged.
  - abort is ignored in GRANT.
- LOAD:
  - ctr_load=1, ctr_load_value=captured value, ctr_up_down=captured direction, ctr_en=0.
  - Clear run-cycle counter rc. Next state RUN.
  - If abort=1: ctr_load still asserts; next state DONE with status 01.
- RUN:
  - ctr_en = !ctr_tc & !abort (combinational), ctr_up_down held.
  - rc increments each RUN cycle.
  - Priority: abort → DONE/01; else ctr_tc → DONE/00 (counter frozen at terminal); else rc==TIMEOUT-1 → DONE/10 with ctr_en=0 that cycle.
  - A start value already at terminal gives DONE after one RUN cycle with zero count steps.
- DONE:
  - done[owner]=1 and done_status valid for this one cycle only.
  - last_grant=owner. Next state IDLE.
  - ctr_en=0, ctr_load=0.
- Latency from first IDLE cycle with valid (t0): ready at t0+1, load at t0+2, RUN starts t0+3.
  - Up job: done at t0+4+(MAX-V).
  - Down job: done at t0+4+V.
- Minimum turnaround between jobs: 1 IDLE cycle after DONE.
- Fairness: a continuously requesting client is granted at most once per NREQ jobs while others wait.
- ctr_up_down keeps the last job direction in IDLE/GRANT. ctr_load_value keeps its last value.
- No simultaneous-event ambiguity: the abort > tc > timeout order is fixed. New requests are never accepted outside IDLE/GRANT.

Test Plan:
- Single job up: WIDTH=8, req_valid[0] with value 250, up at t0 → ready[0] at t0+1; ctr_load at t0+2; ctr_en high 5 cycles; done[0] with status 00 at t0+9.
- Single job down from 0: req 2, value 0, down → one RUN cycle with ctr_en=0; done[2]/00 at t0+4; counter never steps.
- Round-robin: all four valid continuously → grant order 0,1,2,3,0; no requester served twice before every other pending requester is served once.
- Abort: abort=1 on the third RUN cycle of a down job with value 100 → ctr_en=0 that cycle; done[owner]/01 next cycle; the next IDLE grants the following requester.
- Timeout: counter model with tc stuck at 0 → exactly TIMEOUT=257 RUN cycles, then done/10; busy returns low one cycle later.
- Reset mid-RUN plus valid drop: rst_n low during RUN → all outputs 0 immediately, no done pulse, next grant goes to requester 0. Separately, drop req_valid[1] in GRANT → no load, return to IDLE.
